// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, status codes,
// condition functions and the E pipeline register layout.
package y86_pkg;

  localparam int         WORD  = 64;
  localparam logic [3:0] RNONE = 4'hF;

  // instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // ALU function codes
  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  // stage status codes
  localparam logic [2:0] SAOK = 3'h1;
  localparam logic [2:0] SHLT = 3'h2;
  localparam logic [2:0] SADR = 3'h3;
  localparam logic [2:0] SINS = 3'h4;

  // condition functions for jXX / cmovXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // E pipeline register contents
  typedef struct packed {
    logic [2:0]      stat;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [WORD-1:0] val_a;
    logic [WORD-1:0] val_b;
    logic [WORD-1:0] val_c;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
  } ereg_t;

  // reset and bubble share one value: a nop with AOK status
  localparam ereg_t E_NOP = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                              val_a: '0, val_b: '0, val_c: '0,
                              dst_e: RNONE, dst_m: RNONE};

  // exceptional status that blocks CC updates from a later stage
  function automatic logic stat_exc(input logic [2:0] s);
    return (s == SADR) || (s == SHLT) || (s == SINS);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational 64-bit ALU with Y86 flags. Unknown fn gives 0 with flags on 0.
module exec_alu
  import y86_pkg::*;
(
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic [3:0]      fn,
  output logic [WORD-1:0] result,
  output logic            zf,
  output logic            sf,
  output logic            of
);

  // result and overflow per function; SUB is b - a
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fn)
      ALUADD: begin
        result = b + a;
        of     = (a[WORD-1] == b[WORD-1]) && (result[WORD-1] != a[WORD-1]);
      end
      ALUSUB: begin
        result = b - a;
        of     = (a[WORD-1] != b[WORD-1]) && (result[WORD-1] != b[WORD-1]);
      end
      ALUAND: result = a & b;
      ALUXOR: result = a ^ b;
      default: begin
        result = '0;
        of     = 1'b0;
      end
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[WORD-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU and condition codes.
module execute_stage
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            E_bubble,
  input  logic [2:0]      D_stat,
  input  logic [3:0]      D_icode,
  input  logic [3:0]      D_ifun,
  input  logic [WORD-1:0] d_valA,
  input  logic [WORD-1:0] d_valB,
  input  logic [WORD-1:0] D_valC,
  input  logic [3:0]      d_dstE,
  input  logic [3:0]      d_dstM,
  input  logic [2:0]      m_stat,
  input  logic [2:0]      W_stat,
  output logic [2:0]      E_stat,
  output logic [3:0]      E_icode,
  output logic [WORD-1:0] E_valA,
  output logic [3:0]      E_dstM,
  output logic [WORD-1:0] e_valE,
  output logic            e_Cnd,
  output logic [3:0]      e_dstE,
  output logic            cc_zf,
  output logic            cc_sf,
  output logic            cc_of
);

  ereg_t           e_q;
  logic [WORD-1:0] alu_a, alu_b;
  logic [3:0]      alu_fn;
  logic            new_zf, new_sf, new_of;
  logic            set_cc;

  // E register: never stalled, bubble loads a nop, reset wins over bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         e_q <= E_NOP;
    else if (E_bubble) e_q <= E_NOP;
    else               e_q <= '{stat: D_stat, icode: D_icode, ifun: D_ifun,
                                val_a: d_valA, val_b: d_valB, val_c: D_valC,
                                dst_e: d_dstE, dst_m: d_dstM};
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_valA  = e_q.val_a;
  assign E_dstM  = e_q.dst_m;

  // ALU operand and function selection by icode
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_q.icode)
      IRRMOVQ, IOPQ:            alu_a = e_q.val_a;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = e_q.val_c;
      ICALL, IPUSHQ:            alu_a = -64'sd8;
      IRET, IPOPQ:              alu_a = 64'd8;
      default:                  alu_a = '0;
    endcase
    case (e_q.icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = e_q.val_b;
      default:                                            alu_b = '0;
    endcase
  end

  assign alu_fn = (e_q.icode == IOPQ) ? e_q.ifun : ALUADD;

  exec_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fn     (alu_fn),
    .result (e_valE),
    .zf     (new_zf),
    .sf     (new_sf),
    .of     (new_of)
  );

  // only an OPq updates CC, and not while a later stage is excepting
  assign set_cc = (e_q.icode == IOPQ) && !stat_exc(m_stat) && !stat_exc(W_stat);

  // architectural condition codes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= new_zf;
      cc_sf <= new_sf;
      cc_of <= new_of;
    end
  end

  // branch / cmov condition from current CC
  always_comb begin
    e_Cnd = 1'b0;
    case (e_q.ifun)
      C_YES:   e_Cnd = 1'b1;
      C_LE:    e_Cnd = (cc_sf ^ cc_of) | cc_zf;
      C_L:     e_Cnd = cc_sf ^ cc_of;
      C_E:     e_Cnd = cc_zf;
      C_NE:    e_Cnd = !cc_zf;
      C_GE:    e_Cnd = !(cc_sf ^ cc_of);
      C_G:     e_Cnd = !(cc_sf ^ cc_of) && !cc_zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  // a failed cmov writes nothing
  assign e_dstE = ((e_q.icode == IRRMOVQ) && !e_Cnd) ? RNONE : e_q.dst_e;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed plan steps, then random traffic against
// an arithmetic reference model of the E register, ALU and CC.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_bubble;
  logic [2:0]  D_stat, m_stat, W_stat;
  logic [3:0]  D_icode, D_ifun, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, D_valC;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_dstM, e_dstE;
  logic [63:0] E_valA, e_valE;
  logic        e_Cnd, cc_zf, cc_sf, cc_of;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  logic [3:0]  mi, mf, mde, mdm;
  logic [2:0]  mst;
  logic [63:0] mva, mvb, mvc;
  logic        mz, ms, mo;

  execute_stage dut (
    .clk(clk), .reset(reset), .E_bubble(E_bubble), .D_stat(D_stat),
    .D_icode(D_icode), .D_ifun(D_ifun), .d_valA(d_valA), .d_valB(d_valB),
    .D_valC(D_valC), .d_dstE(d_dstE), .d_dstM(d_dstM), .m_stat(m_stat),
    .W_stat(W_stat), .E_stat(E_stat), .E_icode(E_icode), .E_valA(E_valA),
    .E_dstM(E_dstM), .e_valE(e_valE), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  // ALU behaviour from the instruction-set rules; overflow judged by
  // comparing the wrapped result with the exact 65-bit signed value
  task automatic alu_model(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] va, input logic [63:0] vb,
                           input logic [63:0] vc, output logic [63:0] r,
                           output logic z, output logic s, output logic o);
    logic [63:0] a, b;
    logic signed [64:0] exact;
    a = 64'd0; b = 64'd0; r = 64'd0; o = 1'b0;
    if (ic == 4'h2 || ic == 4'h6) a = va;
    else if (ic >= 4'h3 && ic <= 4'h5) a = vc;
    else if (ic == 4'h8 || ic == 4'hA) a = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (ic == 4'h9 || ic == 4'hB) a = 64'd8;
    if (ic >= 4'h4 && ic <= 4'hB && ic != 4'h7) b = vb;
    if (ic != 4'h6 || fn == 4'h0) begin
      r = a + b;
      exact = $signed({a[63], a}) + $signed({b[63], b});
      o = (exact != $signed({r[63], r}));
    end else if (fn == 4'h1) begin
      r = b - a;
      exact = $signed({b[63], b}) - $signed({a[63], a});
      o = (exact != $signed({r[63], r}));
    end else if (fn == 4'h2) r = a & b;
    else if (fn == 4'h3) r = a ^ b;
    z = (r == 64'd0);
    s = r[63];
  endtask

  function automatic logic cond(input logic [3:0] fn, input logic z,
                                input logic s, input logic o);
    case (fn)
      4'h0: return 1'b1;
      4'h1: return (s != o) || z;
      4'h2: return s != o;
      4'h3: return z;
      4'h4: return !z;
      4'h5: return s == o;
      4'h6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic mreset();
    mi = 4'h1; mf = 4'h0; mst = 3'h1; mva = '0; mvb = '0; mvc = '0;
    mde = 4'hF; mdm = 4'hF; mz = 1'b1; ms = 1'b0; mo = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] r; logic z, s, o, c;
    alu_model(mi, mf, mva, mvb, mvc, r, z, s, o);
    c = cond(mf, mz, ms, mo);
    chk({tag, ".E_stat"},  {61'd0, E_stat}, {61'd0, mst});
    chk({tag, ".E_icode"}, {60'd0, E_icode}, {60'd0, mi});
    chk({tag, ".E_valA"},  E_valA, mva);
    chk({tag, ".E_dstM"},  {60'd0, E_dstM}, {60'd0, mdm});
    chk({tag, ".e_valE"},  e_valE, r);
    chk({tag, ".e_Cnd"},   {63'd0, e_Cnd}, {63'd0, c});
    chk({tag, ".e_dstE"},  {60'd0, e_dstE}, (mi == 4'h2 && !c) ? 64'hF : {60'd0, mde});
    chk({tag, ".cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, mz, ms, mo});
  endtask

  function automatic logic exc(input logic [2:0] st);
    return st == 3'h2 || st == 3'h3 || st == 3'h4;
  endfunction

  // drive one cycle of inputs, clock it, advance the model, check
  task automatic step(input string tag, input logic bub, input logic [2:0] dst,
                      input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] va, input logic [63:0] vb,
                      input logic [63:0] vc, input logic [3:0] de,
                      input logic [3:0] dm, input logic [2:0] mst_i,
                      input logic [2:0] wst_i);
    logic [63:0] r; logic z, s, o;
    E_bubble = bub; D_stat = dst; D_icode = ic; D_ifun = fn;
    d_valA = va; d_valB = vb; D_valC = vc; d_dstE = de; d_dstM = dm;
    m_stat = mst_i; W_stat = wst_i;
    alu_model(mi, mf, mva, mvb, mvc, r, z, s, o);
    @(posedge clk);
    #1;
    if (mi == 4'h6 && !exc(mst_i) && !exc(wst_i)) begin
      mz = z; ms = s; mo = o;
    end
    if (bub) begin
      mi = 4'h1; mf = 4'h0; mst = 3'h1; mva = '0; mvb = '0; mvc = '0;
      mde = 4'hF; mdm = 4'hF;
    end else begin
      mi = ic; mf = fn; mst = dst; mva = va; mvb = vb; mvc = vc;
      mde = de; mdm = dm;
    end
    check_all(tag);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return {32'd0, $urandom_range(0, 255)};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    reset = 1'b1; E_bubble = 1'b0; D_stat = 3'h1; D_icode = 4'h1; D_ifun = 4'h0;
    d_valA = '0; d_valB = '0; D_valC = '0; d_dstE = 4'hF; d_dstM = 4'hF;
    m_stat = 3'h1; W_stat = 3'h1;
    mreset();
    #2;
    check_all("reset");
    chk("reset.e_valE0", e_valE, 64'd0);
    chk("reset.e_Cnd1", {63'd0, e_Cnd}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // SUB 1-1 then jle
    step("sub", 0, 3'h1, 4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF, 3'h1, 3'h1);
    chk("sub.valE", e_valE, 64'd0);
    step("jle", 0, 3'h1, 4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 3'h1, 3'h1);
    chk("jle.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    chk("jle.cnd", {63'd0, e_Cnd}, 64'd1);

    // ADD overflow then cmovl
    step("addov", 0, 3'h1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF,
         64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, 4'hF, 3'h1, 3'h1);
    chk("addov.valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    step("cmovl", 0, 3'h1, 4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, 3'h1, 3'h1);
    chk("cmovl.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
    chk("cmovl.cnd", {63'd0, e_Cnd}, 64'd0);
    chk("cmovl.dstE", {60'd0, e_dstE}, 64'hF);

    // asynchronous reset mid-run with CC = {0,1,1}
    reset = 1'b1;
    #1;
    mreset();
    check_all("areset");
    chk("areset.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    // bubble together with reset across an edge
    E_bubble = 1'b1; D_icode = 4'h6; D_stat = 3'h4; d_dstM = 4'h2;
    @(posedge clk); #1;
    check_all("rst_bub");
    reset = 1'b0;

    // address arithmetic, no CC change
    step("push", 0, 3'h1, 4'hA, 4'h0, 64'h9, 64'h100, 64'd0, 4'h4, 4'hF, 3'h1, 3'h1);
    chk("push.valE", e_valE, 64'hF8);
    step("call", 0, 3'h1, 4'h8, 4'h0, 64'h9, 64'h100, 64'h77, 4'h4, 4'hF, 3'h1, 3'h1);
    chk("call.valE", e_valE, 64'hF8);
    step("pop", 0, 3'h1, 4'hB, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 4'h5, 3'h1, 3'h1);
    chk("pop.valE", e_valE, 64'h108);
    step("ret", 0, 3'h1, 4'h9, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 4'hF, 3'h1, 3'h1);
    chk("ret.valE", e_valE, 64'h108);
    step("mrmov", 0, 3'h1, 4'h5, 4'h0, 64'd0, 64'h20, 64'h10, 4'hF, 4'h6, 3'h1, 3'h1);
    chk("mrmov.valE", e_valE, 64'h30);
    chk("mrmov.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);

    // XOR blocked by later-stage exceptions, then allowed
    step("xor1", 0, 3'h1, 4'h6, 4'h3, 64'h5, 64'h3, 64'd0, 4'h1, 4'hF, 3'h1, 3'h1);
    step("xor_madr", 0, 3'h1, 4'h6, 4'h3, 64'h5, 64'h3, 64'd0, 4'h1, 4'hF, 3'h3, 3'h1);
    chk("xor_madr.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    step("xor_whlt", 0, 3'h1, 4'h6, 4'h3, 64'h5, 64'h3, 64'd0, 4'h1, 4'hF, 3'h1, 3'h2);
    chk("xor_whlt.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    step("xor_ok", 0, 3'h1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'h1, 3'h1);
    chk("xor_ok.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);

    // bubble over a valid OPq
    step("bub", 1, 3'h1, 4'h6, 4'h1, 64'h9, 64'h9, 64'd0, 4'h2, 4'h3, 3'h1, 3'h1);
    chk("bub.icode", {60'd0, E_icode}, 64'h1);
    step("bub2", 0, 3'h1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'h1, 3'h1);
    chk("bub2.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic, fn;
      logic [2:0] sm, sw;
      ic = 4'($urandom_range(0, 11));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      sm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'h1;
      sw = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'h1;
      step("rnd", ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 4)), ic, fn,
           rnd64(), rnd64(), rnd64(), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), sm, sw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
